// File: rtl/alu_sequencer.sv
// Control sequencer for a register/ALU datapath: IDLE -> LOAD -> EXEC -> DONE per operation.
// Define ALU_SEQ_MULTI_SHIFT_EN to repeat LOAD/EXEC shamt times for SHL/LSHR/ASHR.
module alu_sequencer #(
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic [3:0]         alu_mode,
  output logic [1:0]         alu_ctrl,
  output logic [1:0]         a_ctrl,
  output logic [1:0]         b_ctrl,
  output logic [1:0]         dst_ctrl,
  output logic               a_from_dst,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               flag_v,
  output logic               flag_z
);

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_NOT  = 4'd5;
  localparam logic [3:0] ALU_OP_SHL  = 4'd6;
  localparam logic [3:0] ALU_OP_ASHR = 4'd8;

  localparam logic [1:0] REG_OP_NONE  = 2'd0;
  localparam logic [1:0] REG_OP_READ  = 2'd1;
  localparam logic [1:0] REG_OP_WRITE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [3:0] o);
    return (o <= ALU_OP_ASHR);
  endfunction

  function automatic logic is_arith(input logic [3:0] o);
    return (o == ALU_OP_ADD) || (o == ALU_OP_SUB);
  endfunction

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] alu_mode_q, alu_mode_d;
  logic [1:0] alu_ctrl_q, alu_ctrl_d;
  logic [1:0] a_ctrl_q, a_ctrl_d;
  logic [1:0] b_ctrl_q, b_ctrl_d;
  logic [1:0] dst_ctrl_q, dst_ctrl_d;
  logic       a_from_dst_q, a_from_dst_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       flag_v_q, flag_v_d;
  logic       flag_z_q, flag_z_d;

`ifdef ALU_SEQ_MULTI_SHIFT_EN
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  function automatic logic is_shift(input logic [3:0] o);
    return (o >= ALU_OP_SHL) && (o <= ALU_OP_ASHR);
  endfunction
`else
  logic unused_shamt_s;
  assign unused_shamt_s = ^shamt;
`endif

  // Next-state, flag capture and registered-output decode from the upcoming state.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    err_d        = 1'b0;
    flag_v_d     = flag_v_q;
    flag_z_d     = flag_z_q;
    a_from_dst_d = 1'b0;
`ifdef ALU_SEQ_MULTI_SHIFT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_legal(op)) begin
            op_d    = op;
            state_d = S_LOAD;
`ifdef ALU_SEQ_MULTI_SHIFT_EN
            cnt_d   = (shamt == '0) ? SHAMT_W'(1) : shamt;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: state_d = S_EXEC;
      S_EXEC: begin
        flag_z_d = alu_zero;
        if (is_arith(op_q)) begin
          flag_v_d = alu_overflow;
        end else begin
          flag_v_d = flag_v_q;
        end
`ifdef ALU_SEQ_MULTI_SHIFT_EN
        // cnt_q counts iterations still owed, including the one just executed
        if (is_shift(op_q) && (cnt_q > SHAMT_W'(1))) begin
          cnt_d        = cnt_q - SHAMT_W'(1);
          state_d      = S_LOAD;
          a_from_dst_d = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    alu_mode_d = ALU_OP_NOT;
    alu_ctrl_d = REG_OP_NONE;
    a_ctrl_d   = REG_OP_NONE;
    b_ctrl_d   = REG_OP_NONE;
    dst_ctrl_d = REG_OP_NONE;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      S_LOAD: begin
        busy_d     = 1'b1;
        alu_mode_d = op_d;
        a_ctrl_d   = REG_OP_WRITE;
        b_ctrl_d   = REG_OP_WRITE;
      end
      S_EXEC: begin
        busy_d     = 1'b1;
        alu_mode_d = op_d;
        alu_ctrl_d = REG_OP_WRITE;
        dst_ctrl_d = REG_OP_READ;
      end
      S_DONE: begin
        busy_d     = 1'b1;
        done_d     = 1'b1;
        alu_mode_d = op_d;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= ALU_OP_NOT;
      alu_mode_q   <= ALU_OP_NOT;
      alu_ctrl_q   <= REG_OP_NONE;
      a_ctrl_q     <= REG_OP_NONE;
      b_ctrl_q     <= REG_OP_NONE;
      dst_ctrl_q   <= REG_OP_NONE;
      a_from_dst_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      flag_v_q     <= 1'b0;
      flag_z_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      alu_mode_q   <= alu_mode_d;
      alu_ctrl_q   <= alu_ctrl_d;
      a_ctrl_q     <= a_ctrl_d;
      b_ctrl_q     <= b_ctrl_d;
      dst_ctrl_q   <= dst_ctrl_d;
      a_from_dst_q <= a_from_dst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      flag_v_q     <= flag_v_d;
      flag_z_q     <= flag_z_d;
    end
  end

`ifdef ALU_SEQ_MULTI_SHIFT_EN
  // Remaining-iteration counter for repeated shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign alu_mode   = alu_mode_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign a_ctrl     = a_ctrl_q;
  assign b_ctrl     = b_ctrl_q;
  assign dst_ctrl   = dst_ctrl_q;
  assign a_from_dst = a_from_dst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign flag_v     = flag_v_q;
  assign flag_z     = flag_z_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: the bench plays the ALU and checks every cycle
// against the expected LOAD/EXEC/DONE schedule and a flag model.
module tb_alu_sequencer;

  localparam int SHAMT_W = 3;
`ifdef ALU_SEQ_MULTI_SHIFT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [1:0] RN = 2'd0;
  localparam logic [1:0] RR = 2'd1;
  localparam logic [1:0] RW = 2'd2;

  logic clk, rst_n, start, alu_overflow, alu_zero;
  logic [3:0] op;
  logic [SHAMT_W-1:0] shamt;
  logic [3:0] alu_mode;
  logic [1:0] alu_ctrl, a_ctrl, b_ctrl, dst_ctrl;
  logic a_from_dst, busy, done, err, flag_v, flag_z;
  logic [15:0] act_vec;

  int n_checks = 0;
  int n_err = 0;
  bit model_v = 1'b0;
  bit model_z = 1'b0;
  bit force_en = 1'b0;
  bit force_z = 1'b0;
  bit force_v = 1'b0;

  alu_sequencer #(.SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shamt(shamt),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .alu_mode(alu_mode), .alu_ctrl(alu_ctrl), .a_ctrl(a_ctrl), .b_ctrl(b_ctrl),
    .dst_ctrl(dst_ctrl), .a_from_dst(a_from_dst), .busy(busy), .done(done),
    .err(err), .flag_v(flag_v), .flag_z(flag_z)
  );

  assign act_vec = {busy, done, err, a_from_dst, alu_mode, alu_ctrl, a_ctrl, b_ctrl, dst_ctrl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu();
    if (force_en) begin
      alu_zero = force_z;
      alu_overflow = force_v;
    end else begin
      alu_zero = 1'($urandom_range(1, 0));
      alu_overflow = 1'($urandom_range(1, 0));
    end
  endtask

  function automatic int iters(input logic [3:0] o, input logic [SHAMT_W-1:0] s);
    if (MULTI && o >= 4'd6 && o <= 4'd8) return (s == 0) ? 1 : int'(s);
    return 1;
  endfunction

  // Expected outputs k cycles after accept for an op that runs n LOAD/EXEC pairs.
  function automatic logic [15:0] exp_vec(input logic [3:0] o, input int k, input int n);
    logic afd;
    afd = (k % 2 == 1) && (k > 1) && (k < 2 * n + 1);
    if (k == 2 * n + 1) return {4'b1100, o, RN, RN, RN, RN};
    if (k % 2 == 1) return {1'b1, 1'b0, 1'b0, afd, o, RN, RW, RW, RN};
    return {4'b1000, o, RW, RN, RN, RR};
  endfunction

  function automatic logic [15:0] idle_vec(input logic e);
    return {2'b00, e, 1'b0, OP_NOT, RN, RN, RN, RN};
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [SHAMT_W-1:0] s, input bit poke_start,
                        input string name);
    int n;
    int lat;
    bit zv[0:31];
    bit vv[0:31];
    n = iters(o, s);
    lat = 2 * n + 1;
    start = 1'b1;
    op = o;
    shamt = s;
    drive_alu();
    tick();
    for (int k = 1; k <= lat; k++) begin
      n_checks++;
      if (act_vec !== exp_vec(o, k, n)) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, act_vec, exp_vec(o, k, n));
      end
      if (k == 1 && poke_start) begin
        start = 1'b1;
        op = OP_SUB;
      end else begin
        start = 1'b0;
      end
      drive_alu();
      zv[k] = alu_zero;
      vv[k] = alu_overflow;
      tick();
    end
    model_z = zv[2 * n];
    if (o == OP_ADD || o == OP_SUB) model_v = vv[2 * n];
    n_checks++;
    if ({act_vec, flag_v, flag_z} !== {idle_vec(1'b0), model_v, model_z}) begin
      n_err++;
      $display("FAIL %s end: got %h v=%b z=%b expected %h v=%b z=%b", name, act_vec, flag_v,
               flag_z, idle_vec(1'b0), model_v, model_z);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op = 4'd0;
    shamt = '0;
    alu_zero = 1'b0;
    alu_overflow = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({act_vec, flag_v, flag_z} !== {idle_vec(1'b0), 2'b00}) begin
      n_err++;
      $display("FAIL reset: got %h v=%b z=%b", act_vec, flag_v, flag_z);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_op();
    run_op(OP_ADD, 3'd0, 1'b0, "pre_reset_add");
    start = 1'b1;
    op = OP_ADD;
    tick();
    start = 1'b0;
    tick();
    alu_zero = 1'b1;
    alu_overflow = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_v = 1'b0;
    model_z = 1'b0;
    n_checks++;
    if ({act_vec, flag_v, flag_z} !== {idle_vec(1'b0), 2'b00}) begin
      n_err++;
      $display("FAIL reset_mid_op: got %h v=%b z=%b", act_vec, flag_v, flag_z);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_op_idle: got done=%b busy=%b expected 0 0", done, busy);
      end
    end
  endtask

  task automatic test_add_overflow();
    force_en = 1'b1;
    force_z = 1'b1;
    force_v = 1'b1;
    run_op(OP_ADD, 3'd0, 1'b0, "add_overflow");
    n_checks++;
    if ({flag_v, flag_z} !== 2'b11) begin
      n_err++;
      $display("FAIL add_overflow_flags: got %b%b expected 11", flag_v, flag_z);
    end
  endtask

  task automatic test_flag_hold();
    force_z = 1'b0;
    force_v = 1'b0;
    run_op(OP_AND, 3'd0, 1'b0, "flag_hold");
    n_checks++;
    if ({flag_v, flag_z} !== 2'b10) begin
      n_err++;
      $display("FAIL flag_hold_flags: got %b%b expected 10", flag_v, flag_z);
    end
    force_en = 1'b0;
  endtask

  task automatic test_busy_ignore();
    run_op(OP_XOR, 3'd0, 1'b1, "busy_ignore");
    for (int i = 0; i < 3; i++) begin
      drive_alu();
      tick();
      n_checks++;
      if (act_vec !== idle_vec(1'b0)) begin
        n_err++;
        $display("FAIL busy_ignore_idle: got %h expected %h", act_vec, idle_vec(1'b0));
      end
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      op = 4'($urandom_range(15, 9));
      drive_alu();
      tick();
      start = 1'b0;
      n_checks++;
      if ({act_vec, flag_v, flag_z} !== {idle_vec(1'b1), model_v, model_z}) begin
        n_err++;
        $display("FAIL illegal op %0d: got %h v=%b z=%b expected %h", op, act_vec, flag_v,
                 flag_z, idle_vec(1'b1));
      end
      tick();
      n_checks++;
      if (act_vec !== idle_vec(1'b0)) begin
        n_err++;
        $display("FAIL illegal_after: got %h expected %h", act_vec, idle_vec(1'b0));
      end
    end
  endtask

  task automatic test_multi_shift();
    run_op(OP_SHL, 3'd3, 1'b0, "shl_3");
    run_op(OP_SHL, 3'd0, 1'b0, "shl_0");
    run_op(4'd8, 3'd7, 1'b0, "ashr_7");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(4'($urandom_range(8, 0)), 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
             "random");
      for (int g = $urandom_range(2, 0); g > 0; g--) begin
        drive_alu();
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_add_overflow();
    test_flag_hold();
    test_busy_ignore();
    test_illegal();
    test_multi_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
